// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte queue feeding a UART transceiver through the
// tx_data/tx_wr/tx_done handshake, with CTS-style hold-off, synchronous
// flush, sticky overflow and a "transmitter emptied" interrupt pulse.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  flush,
    input  logic                  tx_enable,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  idle,
    output logic                  irq_empty,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_done
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  irq_empty_q, irq_empty_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_wr_q, tx_wr_d;

    logic empty;
    logic push;
    logic pop;
    logic can_start;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_COUNT);
    // Full is judged on the registered count, so a same-cycle pop never rescues a write.
    assign push      = wr_en && !full && !flush;
    assign can_start = !empty && tx_enable && !flush;

    assign level     = count_q;
    assign overflow  = overflow_q;
    assign idle      = (state_q == ST_IDLE) && empty;
    assign irq_empty = irq_empty_q;
    assign tx_data   = tx_data_q;
    assign tx_wr     = tx_wr_q;

    // Handshake FSM: decide when a byte is popped and when the queue has drained.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        irq_empty_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (can_start) begin
                    pop     = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (tx_done) begin
                    if (can_start) begin
                        pop = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        irq_empty_d = empty || flush;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Queue bookkeeping: pointers, occupancy, overflow and the presented byte.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_data_d  = tx_data_q;
        tx_wr_d    = pop;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                tx_data_d = mem_q[rd_ptr_q];
            end
            if (push && !pop) count_d = count_q + CNT_ONE;
            if (!push && pop) count_d = count_q - CNT_ONE;
            if (wr_en && full) overflow_d = 1'b1;
        end
    end

    // Control and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            irq_empty_q <= 1'b0;
            tx_data_q   <= '0;
            tx_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            irq_empty_q <= irq_empty_d;
            tx_data_q   <= tx_data_d;
            tx_wr_q     <= tx_wr_d;
        end
    end

    // Byte storage; contents need no reset since occupancy is tracked by count_q.
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH_LOG2 = 4, 16 entries).
module tb_uart_tx_fifo;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       flush = 1'b0;
    logic       tx_enable = 1'b0;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       idle;
    logic       irq_empty;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_done = 1'b0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .flush     (flush),
        .tx_enable (tx_enable),
        .full      (full),
        .level     (level),
        .overflow  (overflow),
        .idle      (idle),
        .irq_empty (irq_empty),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_done   (tx_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Wait (bounded) for a tx_wr, check its byte, then confirm the pulse is one cycle wide.
    task automatic expect_byte(input string tag, input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (tx_wr) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_seen"}, ok, 1);
        check({tag, "_data"}, tx_data, d);
        tick();
        check({tag, "_1cyc"}, tx_wr, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_tx_wr", tx_wr, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_irq", irq_empty, 0);
        check("rst_idle", idle, 1);
        sys_rst_n = 1'b1;
        tx_enable = 1'b1;
        tick();

        // Single byte latency: wr_en in k, level 1 in k+1, tx_wr in k+2
        push(8'h55);
        check("t1_level_k1", level, 1);
        check("t1_txwr_k1", tx_wr, 0);
        check("t1_idle_k1", idle, 0);
        tick();
        check("t1_txwr_k2", tx_wr, 1);
        check("t1_data_k2", tx_data, 8'h55);
        check("t1_level_k2", level, 0);
        tick();
        check("t1_txwr_k3", tx_wr, 0);
        check("t1_irq_wait", irq_empty, 0);
        done_pulse();
        check("t1_irq", irq_empty, 1);
        check("t1_idle", idle, 1);
        tick();
        check("t1_irq_1cyc", irq_empty, 0);

        // Fill to full with hold-off, overflow, then drain in order
        tx_enable = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t2_full", full, 1);
        check("t2_level16", level, 16);
        check("t2_no_ovf", overflow, 0);
        check("t2_no_start", tx_wr, 0);
        push(8'hAA);
        check("t2_overflow", overflow, 1);
        check("t2_level_still16", level, 16);
        tx_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_byte("t2_byte", 8'(i));
            check("t2_no_irq", irq_empty, 0);
            done_pulse();
            if (i < 15) check("t2_irq_early", irq_empty, 0);
        end
        check("t2_irq_last", irq_empty, 1);
        check("t2_idle_last", idle, 1);
        check("t2_full_gone", full, 0);

        // Flush while BUSY at level 3 with a same-cycle push
        tx_enable = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        tx_enable = 1'b1;
        expect_byte("t4_first", 8'hC0);
        check("t4_level3", level, 3);
        check("t4_ovf_before", overflow, 1);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hDD;
        tick();
        flush   = 1'b0;
        wr_en   = 1'b0;
        check("t4_level0", level, 0);
        check("t4_ovf_clr", overflow, 0);
        check("t4_still_busy", idle, 0);
        check("t4_no_wr", tx_wr, 0);
        tick();
        check("t4_wait_done", irq_empty, 0);
        done_pulse();
        check("t4_irq", irq_empty, 1);
        check("t4_idle", idle, 1);
        check("t4_dropped", level, 0);
        tick();

        // Simultaneous push and pop at level 5
        tx_enable = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
        tx_enable = 1'b1;
        expect_byte("t3_first", 8'hA0);
        check("t3_level5", level, 5);
        tx_done = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hB0;
        tick();
        tx_done = 1'b0;
        wr_en   = 1'b0;
        check("t3_level_same", level, 5);
        for (int i = 1; i < 6; i++) begin
            expect_byte("t3_byte", 8'hA0 + 8'(i));
            done_pulse();
        end
        expect_byte("t3_pushed", 8'hB0);
        done_pulse();
        check("t3_irq", irq_empty, 1);
        tick();

        // Drop tx_enable mid-byte with level 2
        tx_enable = 1'b0;
        for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i));
        tx_enable = 1'b1;
        expect_byte("t5_first", 8'hE0);
        check("t5_level2", level, 2);
        tx_enable = 1'b0;
        done_pulse();
        check("t5_no_wr", tx_wr, 0);
        check("t5_no_irq", irq_empty, 0);
        check("t5_not_idle", idle, 0);
        check("t5_level_kept", level, 2);
        repeat (3) tick();
        check("t5_parked", tx_wr, 0);
        tx_enable = 1'b1;
        tick();
        check("t5_resume_wr", tx_wr, 1);
        check("t5_resume_data", tx_data, 8'hE1);
        tick();
        done_pulse();
        expect_byte("t5_last", 8'hE2);
        done_pulse();
        check("t5_irq", irq_empty, 1);
        tick();

        // Stray tx_done in IDLE
        done_pulse();
        check("t6_stray_irq", irq_empty, 0);
        check("t6_stray_idle", idle, 1);
        check("t6_stray_wr", tx_wr, 0);

        // Asynchronous reset mid-BUSY
        push(8'hF0);
        push(8'hF1);
        check("t6_busy_wr", tx_wr, 1);
        check("t6_busy_data", tx_data, 8'hF0);
        tick();
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("t6_ar_tx_data", tx_data, 8'h00);
        check("t6_ar_level", level, 0);
        check("t6_ar_idle", idle, 1);
        check("t6_ar_full", full, 0);
        check("t6_ar_ovf", overflow, 0);
        check("t6_ar_irq", irq_empty, 0);
        check("t6_ar_tx_wr", tx_wr, 0);
        repeat (2) tick();
        check("t6_in_reset_wr", tx_wr, 0);
        sys_rst_n = 1'b1;
        tick();
        check("t6_post_wr", tx_wr, 0);
        check("t6_post_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit queue placed directly upstream of the UART transceiver. Buffers bytes written by the CSR/bus side in a 2^DEPTH_LOG2-entry FIFO and feeds them one at a time to the transceiver's tx_data/tx_wr/tx_done handshake. It also provides level, full, overflow, idle and "transmitter emptied" interrupt indications. It supports a CTS-style hold-off and a synchronous flush.

## Interface
- DEPTH_LOG2, default 4: FIFO depth = 2^DEPTH_LOG2 entries (legal 1..8).
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe, one byte per cycle high.
- flush  in  1  synchronous FIFO clear, single-cycle pulse or level.
- tx_enable  in  1  when low, no new byte is started (flow-control hold-off).
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- level  out  DEPTH_LOG2+1  number of stored entries, excluding the byte in flight.
- overflow  out  1  sticky; set when wr_en is dropped because of full.
- idle  out  1  FIFO empty and no byte in flight.
- irq_empty  out  1  one-cycle pulse when the last queued byte completes.
- tx_data  out  8  byte presented to the transceiver.
- tx_wr  out  1  one-cycle start pulse to the transceiver.
- tx_done  in  1  one-cycle completion pulse from the transceiver.

## Operation
- Storage: circular buffer with rd_ptr/wr_ptr of DEPTH_LOG2 bits, wrapping naturally modulo depth. Count register is DEPTH_LOG2+1 bits. full = (count == 2^DEPTH_LOG2). empty = (count == 0). Both derive from the registered count.
- Push: wr_en && !full && !flush writes mem[wr_ptr] and increments wr_ptr.
- wr_en && full: the byte is discarded, overflow is set, and pointers are unchanged. This holds even if a pop occurs in the same cycle.
- FSM states:
  - IDLE → BUSY when !empty && tx_enable && !flush. At that edge: tx_data <= mem[rd_ptr], tx_wr <= 1, rd_ptr increments.
  - BUSY: wait for tx_done. On tx_done:
    - If !empty && tx_enable && !flush, pop the next byte and pulse tx_wr again, staying in BUSY.
    - Otherwise go to IDLE. irq_empty <= 1 if empty, or if flush is asserted in that cycle.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- tx_wr is high for exactly one cycle per byte. tx_data is held stable from the tx_wr cycle until the next pop.
- tx_done while in IDLE is ignored (no state change, no irq).
- tx_enable low: the byte in flight completes normally and the FSM then parks in IDLE with data retained. irq_empty does not pulse unless the FIFO is empty.
- flush:
  - Zeroes both pointers and count, and clears overflow.
  - Takes priority over a same-cycle push and a same-cycle pop.
  - Does not abort a byte already handed to the transceiver. BUSY persists until tx_done.
- level = count. idle = (state == IDLE) && empty.

## Timing
- Reset values: tx_wr 0, tx_data 8'h00, full 0, level 0, overflow 0, irq_empty 0, idle 1, state IDLE, pointers 0.
- Latency from push into an empty, idle queue (tx_enable high): wr_en high in cycle k, level = 1 in cycle k+1, tx_wr high in cycle k+2, level back to 0 in cycle k+2.
- Back-to-back: tx_done high in cycle m with a non-empty FIFO gives tx_wr high in cycle m+1.
- irq_empty is high in cycle m+1 when tx_done in cycle m finds the FIFO empty. idle rises in the same cycle.
- full and level reflect writes one cycle after wr_en.
- Reset asserted mid-byte returns all outputs to reset values immediately (asynchronous). No tx_wr is issued until reset is released.

## Test plan
- Reset, then push 8'h55 once with tx_enable=1 → tx_wr pulses once in cycle k+2 with tx_data=8'h55. After tx_done: irq_empty pulses one cycle later and idle=1.
- Push 16 bytes 8'h00..8'h0F in consecutive cycles with tx_enable=0 → full=1 and level=16. A 17th push sets overflow=1 and level stays 16. Set tx_enable=1 and answer each tx_wr with tx_done → output order is 8'h00..8'h0F, one tx_wr per tx_done, irq_empty only after the 16th.
- Pop and push in the same cycle at level=5 → level stays 5, and the pushed byte emerges in FIFO order.
- Flush while BUSY with level=3 and wr_en same cycle → level=0, overflow=0, and the pushed byte is dropped. The pending tx_done still returns to IDLE with irq_empty.
- Drop tx_enable during a byte with level=2 → no tx_wr after tx_done and no irq_empty. Raising tx_enable gives tx_wr the next cycle.
- Stray tx_done in IDLE → no state change, no irq. Assert sys_rst_n low mid-BUSY → all outputs return to reset values without waiting for a clock edge.
